exp_taylor_cfg_pp: RTL



---
 rtl/exp_taylor_cfg_pp.sv | 101 ++++++++++
 1 files changed

// File: rtl/exp_taylor_cfg_pp.sv
// exp_taylor_cfg_pp: pipelined e^x for unsigned fractional x in [0,1).
// Horner-form Taylor series truncated at a per-beat order (0..MAX_ORDER).
// One stage per Taylor term, highest term first. The pipeline moves only when
// the output register is empty or being drained, so a stall freezes every stage.
module exp_taylor_cfg_pp #(
  parameter int IW        = 12,
  parameter int OW        = 20,
  parameter int MAX_ORDER = 6,
  parameter int RW        = 16,
  localparam int OrdW     = $clog2(MAX_ORDER + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   iData,
  input  logic [OrdW-1:0] iOrder,
  input  logic            iDataValid,
  output logic            iReady,
  output logic [OW-1:0]   oData,
  output logic            oDataValid,
  input  logic            oReady
);

  localparam logic [OW-1:0] ONE = OW'(1) << (OW - 2);
  localparam int ProdW = OW + IW;
  localparam int MulW  = OW + RW + 1;
  // The final stage never forwards x/order, so those registers stop one stage early.
  localparam int PassN = (MAX_ORDER > 1) ? MAX_ORDER - 1 : 1;

  logic            advance;
  logic [OrdW-1:0] ordClamp;

  logic            vldR    [1:MAX_ORDER];
  logic [OW-1:0]   accR    [1:MAX_ORDER];
  logic [OW-1:0]   accNext [1:MAX_ORDER];
  logic [IW-1:0]   xR      [1:PassN];
  logic [OrdW-1:0] ordR    [1:PassN];

  assign advance  = !oDataValid || oReady;
  assign iReady   = advance;
  assign ordClamp = (iOrder > OrdW'(MAX_ORDER)) ? OrdW'(MAX_ORDER) : iOrder;

  assign oData      = accR[MAX_ORDER];
  assign oDataValid = vldR[MAX_ORDER];

  for (genvar s = 1; s <= MAX_ORDER; s++) begin : gStage
    localparam int K = MAX_ORDER - s + 1;
    localparam logic [RW:0] RECIP = (RW + 1)'(((64'd1 << RW) + 64'(K / 2)) / 64'(K));

    logic [IW-1:0]   xPrev;
    logic [OrdW-1:0] ordPrev;
    logic [OW-1:0]   accPrev;
    logic [OW-1:0]   tVal;
    logic [OW-1:0]   newAcc;

    if (s == 1) begin : gFirst
      assign xPrev   = iData;
      assign ordPrev = ordClamp;
      assign accPrev = ONE;
    end else begin : gNext
      assign xPrev   = xR[s-1];
      assign ordPrev = ordR[s-1];
      assign accPrev = accR[s-1];
    end

    // Full-width products; truncation happens only at the two shifts.
    assign tVal    = OW'((ProdW'(accPrev) * ProdW'(xPrev)) >> IW);
    assign newAcc  = ONE + OW'((MulW'(tVal) * MulW'(RECIP)) >> RW);
    // Terms above this beat's order pass the accumulator through untouched.
    assign accNext[s] = (OrdW'(K) <= ordPrev) ? newAcc : accPrev;
  end

  // Stage registers: clear on reset, shift together on advance, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 1; s <= MAX_ORDER; s++) begin
        vldR[s] <= 1'b0;
        accR[s] <= '0;
      end
      for (int s = 1; s <= PassN; s++) begin
        xR[s]   <= '0;
        ordR[s] <= '0;
      end
    end else if (advance) begin
      vldR[1] <= iDataValid;
      accR[1] <= accNext[1];
      for (int s = 2; s <= MAX_ORDER; s++) begin
        vldR[s] <= vldR[s-1];
        accR[s] <= accNext[s];
      end
      if (MAX_ORDER > 1) begin
        xR[1]   <= iData;
        ordR[1] <= ordClamp;
      end
      for (int s = 2; s <= PassN; s++) begin
        xR[s]   <= xR[s-1];
        ordR[s] <= ordR[s-1];
      end
    end
  end

endmodule
